// File: rtl/pr_release_queue.sv
// pr_release_queue
//   Commit-side source of freed physical registers. Rename pushes one record
//   {has_dest, old_pr} per renamed instruction, in program order. Retirement
//   pops records in order. The old_pr values of popped dest-writing records
//   are packed into registered lanes that feed the free list.
//
//   Ports
//     clk, rst_n               clock (rising edge), async active-low reset
//     stall                    freezes every register
//     flush, flush_pos         mispredict recovery; tail <= flush_pos
//     alloc_valid/has_dest     4 rename slots; old_pr_in0..3 = previous mappings
//     commit_cnt               instructions retiring this cycle (0..4)
//     free_pr_num_out0..3      packed freed PRs; unused lanes are 0
//     free_pr_cnt              number of valid lanes
//     tail_pos                 current tail, checkpointed by rename
//     queue_full/queue_empty   occupancy > DEPTH-4 / occupancy == 0
//     err_flag                 only when PR_RELEASE_CHECK_EN is defined:
//                              sticky over-commit / write-while-full flag
module pr_release_queue #(
  parameter int DEPTH = 64,
  parameter int PR_W  = 6,
  parameter int PTR_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [PTR_W-1:0] flush_pos,
  input  logic [3:0]       alloc_valid,
  input  logic [3:0]       alloc_has_dest,
  input  logic [PR_W-1:0]  old_pr_in0,
  input  logic [PR_W-1:0]  old_pr_in1,
  input  logic [PR_W-1:0]  old_pr_in2,
  input  logic [PR_W-1:0]  old_pr_in3,
  input  logic [2:0]       commit_cnt,
  output logic [PR_W-1:0]  free_pr_num_out0,
  output logic [PR_W-1:0]  free_pr_num_out1,
  output logic [PR_W-1:0]  free_pr_num_out2,
  output logic [PR_W-1:0]  free_pr_num_out3,
  output logic [2:0]       free_pr_cnt,
  output logic [PTR_W-1:0] tail_pos,
`ifdef PR_RELEASE_CHECK_EN
  output logic             err_flag,
`endif
  output logic             queue_full,
  output logic             queue_empty
);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]           head, tail, occ;
  logic [DEPTH-1:0]           rec_dest;
  logic [DEPTH-1:0][PR_W-1:0] rec_pr;
  logic [3:0][PR_W-1:0]       old_pr, pk_pr, out_pr;
  logic [3:0][2:0]            wr_off;
  logic [3:0][IDX_W-1:0]      wr_idx, rd_idx;
  logic [2:0]                 alloc_n, pop_n, pk_cnt, out_cnt;
  logic                       wr_en;

  assign old_pr[0] = old_pr_in0;
  assign old_pr[1] = old_pr_in1;
  assign old_pr[2] = old_pr_in2;
  assign old_pr[3] = old_pr_in3;

  // Wrap bit makes tail-head the true occupancy even across passes.
  assign occ         = tail - head;
  assign queue_full  = occ > PTR_W'(DEPTH - 4);
  assign queue_empty = (tail == head);
  assign tail_pos    = tail;
  assign wr_en       = !flush && !queue_full;

  // Compaction: each valid slot lands at tail + (valid slots before it).
  always_comb begin
    alloc_n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      wr_off[i] = alloc_n;
      alloc_n   = alloc_n + {2'b0, alloc_valid[i]};
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign wr_idx[g] = tail[IDX_W-1:0] + IDX_W'(wr_off[g]);
    assign rd_idx[g] = head[IDX_W-1:0] + IDX_W'(g);
  end

  // Pop size clamped to pre-edge occupancy, so same-cycle writes never pop.
  always_comb begin
    pop_n = (commit_cnt > 3'd4) ? 3'd4 : commit_cnt;
    if (PTR_W'(pop_n) > occ) pop_n = occ[2:0];
  end

  // Pack has_dest records of the popped window into lanes in age order.
  always_comb begin
    pk_pr  = '0;
    pk_cnt = 3'd0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < pop_n && rec_dest[rd_idx[j]]) begin
        pk_pr[pk_cnt[1:0]] = rec_pr[rd_idx[j]];
        pk_cnt             = pk_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      rec_dest <= '0;
      rec_pr   <= '0;
      out_pr   <= '0;
      out_cnt  <= 3'd0;
    end else if (!stall) begin
      head    <= head + PTR_W'(pop_n);
      out_pr  <= pk_pr;
      out_cnt <= pk_cnt;
      if (flush)
        tail <= flush_pos;
      else if (!queue_full)
        tail <= tail + PTR_W'(alloc_n);
      if (wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (alloc_valid[i]) begin
            rec_dest[wr_idx[i]] <= alloc_has_dest[i];
            rec_pr[wr_idx[i]]   <= alloc_has_dest[i] ? old_pr[i] : '0;
          end
        end
      end
    end
  end

  assign free_pr_num_out0 = out_pr[0];
  assign free_pr_num_out1 = out_pr[1];
  assign free_pr_num_out2 = out_pr[2];
  assign free_pr_num_out3 = out_pr[3];
  assign free_pr_cnt      = out_cnt;

`ifdef PR_RELEASE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_flag <= 1'b0;
    else if (!stall && ((PTR_W'(commit_cnt) > occ) || (|alloc_valid && queue_full)))
      err_flag <= 1'b1;
  end
`endif

endmodule
